autotest_sequencer: RTL and testbench

- Sequences one autotest run of a unit-under-test (UUT): generates input vectors, paces them with an internal clock divider, and captures both UUT output words.
- Packs captured outputs into a 512-byte block buffer.
- Issues one SD block-write request per filled buffer, addressed from START_BLOCK upward.
- Sits between the UUT wrapper and the SD write path of the autotest core.

---
 rtl/autotest_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_autotest_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/autotest_sequencer.sv
// autotest_sequencer: paces UUT stimulus vectors, packs both result bytes
// into a 512-byte block buffer and requests one SD block write per full buffer.
// Optional watchdog on the UUT handshake: define AUTOTEST_TIMEOUT_EN.
module autotest_sequencer #(
  parameter int unsigned CLK_INTERNAL_DIVIDER = 17,
  parameter int unsigned SIZE_INPUT_UUT_1     = 32,
  parameter int unsigned SIZE_OUTPUT_UUT_1    = 8,
  parameter int unsigned SIZE_OUTPUT_UUT_2    = 8,
  parameter logic [31:0] START_BLOCK          = 32'h00100000,
  parameter int unsigned NUM_BLOCKS           = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [SIZE_INPUT_UUT_1-1:0]  uut_input,
  output logic                         uut_start,
  input  logic                         uut_done,
  input  logic [SIZE_OUTPUT_UUT_1-1:0] uut_out_1,
  input  logic [SIZE_OUTPUT_UUT_2-1:0] uut_out_2,
  output logic                         buf_we,
  output logic [8:0]                   buf_addr,
  output logic [7:0]                   buf_wdata,
  output logic                         sd_write_req,
  output logic [31:0]                  sd_block_addr,
  input  logic                         sd_write_ack,
  output logic                         busy,
  output logic                         finished,
  output logic                         error
);

  localparam int unsigned DIV_W      = CLK_INTERNAL_DIVIDER;
  localparam int unsigned VEC_W      = SIZE_INPUT_UUT_1;
  localparam int unsigned PTR_W      = 9;
  localparam int unsigned BLK_W      = 32;
  localparam logic [BLK_W-1:0] LAST_BLOCK = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(511);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_TICK,
    WAIT_UUT,
    WR_B0,
    WR_B1,
    SD_REQ,
    DONE
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div;
  logic [VEC_W-1:0]   vec;
  logic [PTR_W-1:0]   ptr;
  logic [BLK_W-1:0]   blk;
  logic [7:0]         out2_q;
  logic               tick;

`ifdef AUTOTEST_TIMEOUT_EN
  logic [15:0]        wd;
`else
  assign error = 1'b0;
`endif

  // Step tick when the free-running divider reaches all-ones
  assign tick = &div;

  // Sequencer FSM; byte-write outputs are loaded on entry so they are
  // visible during WR_B0/WR_B1, one cycle after uut_done is sampled
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div           <= '0;
      vec           <= '0;
      ptr           <= '0;
      blk           <= '0;
      out2_q        <= '0;
      uut_input     <= '0;
      uut_start     <= 1'b0;
      buf_we        <= 1'b0;
      buf_addr      <= '0;
      buf_wdata     <= '0;
      sd_write_req  <= 1'b0;
      sd_block_addr <= '0;
      busy          <= 1'b0;
      finished      <= 1'b0;
`ifdef AUTOTEST_TIMEOUT_EN
      wd            <= '0;
      error         <= 1'b0;
`endif
    end else begin
      div       <= div + DIV_W'(1);
      uut_start <= 1'b0;
      buf_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= WAIT_TICK;
            busy     <= 1'b1;
            finished <= 1'b0;
            vec      <= '0;
            ptr      <= '0;
            blk      <= '0;
`ifdef AUTOTEST_TIMEOUT_EN
            error    <= 1'b0;
`endif
          end
        end
        WAIT_TICK: begin
          if (tick) begin
            uut_input <= vec;
            uut_start <= 1'b1;
            state     <= WAIT_UUT;
`ifdef AUTOTEST_TIMEOUT_EN
            wd        <= '0;
`endif
          end
        end
        WAIT_UUT: begin
          if (uut_done) begin
            buf_we    <= 1'b1;
            buf_addr  <= ptr;
            buf_wdata <= 8'(uut_out_1);
            out2_q    <= 8'(uut_out_2);
            ptr       <= ptr + PTR_W'(1);
            state     <= WR_B0;
          end
`ifdef AUTOTEST_TIMEOUT_EN
          else if (wd == 16'hFFFF) begin
            // UUT never answered: record marker bytes and keep the run going
            buf_we    <= 1'b1;
            buf_addr  <= ptr;
            buf_wdata <= 8'hEE;
            out2_q    <= 8'hEE;
            ptr       <= ptr + PTR_W'(1);
            error     <= 1'b1;
            state     <= WR_B0;
          end else begin
            wd <= wd + 16'd1;
          end
`endif
        end
        WR_B0: begin
          buf_we    <= 1'b1;
          buf_addr  <= ptr;
          buf_wdata <= out2_q;
          ptr       <= ptr + PTR_W'(1);
          vec       <= vec + VEC_W'(1);
          state     <= WR_B1;
        end
        WR_B1: begin
          if (buf_addr == LAST_PTR) begin
            sd_write_req  <= 1'b1;
            sd_block_addr <= START_BLOCK + blk;
            state         <= SD_REQ;
          end else begin
            state <= WAIT_TICK;
          end
        end
        SD_REQ: begin
          if (sd_write_ack) begin
            sd_write_req <= 1'b0;
            blk          <= blk + BLK_W'(1);
            ptr          <= '0;
            if (blk == LAST_BLOCK) begin
              busy     <= 1'b0;
              finished <= 1'b1;
              state    <= DONE;
            end else begin
              state <= WAIT_TICK;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_autotest_sequencer.sv
// Testbench for autotest_sequencer: UUT model with a response table feeds an
// expected-byte scoreboard; SD acknowledgements and resets are hand-sequenced.
module tb_autotest_sequencer;

  localparam logic [31:0] START_BLOCK = 32'h00100000;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] uut_input;
  logic        uut_start;
  logic        uut_done;
  logic [7:0]  uut_out_1;
  logic [7:0]  uut_out_2;
  logic        buf_we;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        sd_write_req;
  logic [31:0] sd_block_addr;
  logic        sd_write_ack;
  logic        busy;
  logic        finished;
  logic        error;

  autotest_sequencer #(
    .CLK_INTERNAL_DIVIDER(2),
    .SIZE_INPUT_UUT_1(32),
    .SIZE_OUTPUT_UUT_1(8),
    .SIZE_OUTPUT_UUT_2(8),
    .START_BLOCK(START_BLOCK),
    .NUM_BLOCKS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .uut_input(uut_input),
    .uut_start(uut_start),
    .uut_done(uut_done),
    .uut_out_1(uut_out_1),
    .uut_out_2(uut_out_2),
    .buf_we(buf_we),
    .buf_addr(buf_addr),
    .buf_wdata(buf_wdata),
    .sd_write_req(sd_write_req),
    .sd_block_addr(sd_block_addr),
    .sd_write_ack(sd_write_ack),
    .busy(busy),
    .finished(finished),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned dly;
    logic [7:0]  o1;
    logic [7:0]  o2;
    logic [31:0] exp_input;
    logic [8:0]  exp_addr;
  } vec_rec_t;

  typedef struct {
    logic [8:0] addr;
    logic [7:0] data;
  } byte_t;

  vec_rec_t    tbl [4];
  int unsigned tbl_idx;
  byte_t       sb [$];
  int          checks;
  int          failures;
  int          nbytes;
  logic [31:0] exp_vec;
  logic [8:0]  exp_ptr;
  bit          uut_mute;

  int unsigned m_d;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic [8:0]  m_ad;
  byte_t       m_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // UUT model: answers each uut_start and pushes the bytes it expects written
  initial begin
    uut_done  = 1'b0;
    uut_out_1 = 8'h00;
    uut_out_2 = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (uut_start) begin
        chk("uut_input", 64'(uut_input), 64'(exp_vec));
        if (tbl_idx < 4) begin
          m_d  = tbl[tbl_idx].dly;
          m_a  = tbl[tbl_idx].o1;
          m_b  = tbl[tbl_idx].o2;
          m_ad = tbl[tbl_idx].exp_addr;
          chk("tbl_input", 64'(uut_input), 64'(tbl[tbl_idx].exp_input));
          tbl_idx++;
        end else begin
          m_a  = exp_vec[7:0];
          m_b  = exp_vec[7:0];
          m_d  = int'(exp_vec % 32'd3);
          m_ad = exp_ptr;
        end
        if (uut_mute) begin
          m_a = 8'hEE;
          m_b = 8'hEE;
        end
        sb.push_back('{addr: m_ad, data: m_a});
        sb.push_back('{addr: 9'(m_ad + 9'd1), data: m_b});
        exp_ptr = 9'(m_ad + 9'd2);
        exp_vec = exp_vec + 32'd1;
        if (!uut_mute) begin
          repeat (m_d) begin @(posedge clk); #1; end
          uut_done  = 1'b1;
          uut_out_1 = m_a;
          uut_out_2 = m_b;
          @(posedge clk); #1;
          uut_done  = 1'b0;
        end
      end
    end
  end

  // Buffer-write monitor: pops the scoreboard on every buf_we
  initial begin
    forever begin
      @(posedge clk); #1;
      if (buf_we) begin
        nbytes++;
        chk("we_during_req", 64'(sd_write_req), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL buf_unexpected addr=%0h data=%0h required=no_write", buf_addr, buf_wdata);
        end else begin
          m_e = sb.pop_front();
          chk("buf_addr", 64'(buf_addr), 64'(m_e.addr));
          chk("buf_wdata", 64'(buf_wdata), 64'(m_e.data));
        end
      end
    end
  end

  // Global time limit
  initial begin
    #(950000 * 10);
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic model_reset();
    exp_vec = 32'd0;
    exp_ptr = 9'd0;
    sb.delete();
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sd_write_req) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic ack_now();
    sd_write_ack = 1'b1;
    @(posedge clk); #1;
    sd_write_ack = 1'b0;
  endtask

  task automatic check_block(input string name, input logic [31:0] addr);
    bit ok;
    wait_req(20000, ok);
    chk({name, "_seen"}, 64'(ok), 64'd1);
    chk({name, "_addr"}, 64'(sd_block_addr), 64'(addr));
    chk({name, "_bytes"}, 64'(nbytes), 64'd512);
    nbytes = 0;
  endtask

  int  bad;
`ifdef AUTOTEST_TIMEOUT_EN
  bit  seen;
`endif

  initial begin
    tbl[0] = '{dly: 3, o1: 8'hA5, o2: 8'h3C, exp_input: 32'd0, exp_addr: 9'd0};
    tbl[1] = '{dly: 0, o1: 8'h5A, o2: 8'hC3, exp_input: 32'd1, exp_addr: 9'd2};
    tbl[2] = '{dly: 1, o1: 8'hFF, o2: 8'h00, exp_input: 32'd2, exp_addr: 9'd4};
    tbl[3] = '{dly: 5, o1: 8'h01, o2: 8'h80, exp_input: 32'd3, exp_addr: 9'd6};
    tbl_idx      = 0;
    checks       = 0;
    failures     = 0;
    nbytes       = 0;
    uut_mute     = 1'b0;
    rst          = 1'b1;
    start        = 1'b0;
    sd_write_ack = 1'b0;
    model_reset();

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uut_input", 64'(uut_input), 64'd0);
    chk("rst_uut_start", 64'(uut_start), 64'd0);
    chk("rst_buf_we", 64'(buf_we), 64'd0);
    chk("rst_buf_addr", 64'(buf_addr), 64'd0);
    chk("rst_buf_wdata", 64'(buf_wdata), 64'd0);
    chk("rst_sd_req", 64'(sd_write_req), 64'd0);
    chk("rst_sd_addr", 64'(sd_block_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_finished", 64'(finished), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (uut_start || buf_we || busy) bad++;
    end
    chk("idle_quiet", 64'(bad), 64'd0);

    // Run 1: table vectors, echo afterwards, delayed ack on the first block
    pulse_start();
    chk("run1_busy", 64'(busy), 64'd1);
    chk("run1_finished_low", 64'(finished), 64'd0);
    check_block("run1_blk0", START_BLOCK);
    chk("run1_sb_empty", 64'(sb.size()), 64'd0);
    chk("run1_tbl_used", 64'(tbl_idx), 64'd4);
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (!sd_write_req || buf_we || uut_start) bad++;
    end
    chk("req_held", 64'(bad), 64'd0);
    ack_now();
    chk("req_drop", 64'(sd_write_req), 64'd0);
    chk("busy_mid", 64'(busy), 64'd1);
    check_block("run1_blk1", START_BLOCK + 32'd1);
    repeat (3) @(posedge clk);
    #1;
    ack_now();
    chk("run1_req_drop", 64'(sd_write_req), 64'd0);
    chk("run1_finished", 64'(finished), 64'd1);
    chk("run1_busy_done", 64'(busy), 64'd0);
    chk("run1_error", 64'(error), 64'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("finished_sticky", 64'(finished), 64'd1);
    chk("busy_idle", 64'(busy), 64'd0);

    // start clears finished; reset right away in WAIT_TICK
    pulse_start();
    chk("restart_finished_clr", 64'(finished), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_wait_busy", 64'(busy), 64'd0);

    // Run 2: reset while the second block request is pending
    nbytes = 0;
    pulse_start();
    check_block("run2_blk0", START_BLOCK);
    ack_now();
    check_block("run2_blk1", START_BLOCK + 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("midrst_req", 64'(sd_write_req), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_we", 64'(buf_we), 64'd0);
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (uut_start || buf_we || busy || sd_write_req) bad++;
    end
    chk("midrst_idle", 64'(bad), 64'd0);

    // Run 3: must restart at vector 0 and the first block address
    nbytes = 0;
    pulse_start();
    check_block("run3_blk0", START_BLOCK);
    ack_now();
    check_block("run3_blk1", START_BLOCK + 32'd1);
    ack_now();
    chk("run3_finished", 64'(finished), 64'd1);
    chk("run3_busy", 64'(busy), 64'd0);

`ifdef AUTOTEST_TIMEOUT_EN
    // Watchdog: silent UUT yields EE/EE bytes and sticky error
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    nbytes   = 0;
    uut_mute = 1'b1;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      if (error) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    uut_mute = 1'b0;
    chk("timeout_error", 64'(seen), 64'd1);
    bad = 0;
    while (nbytes < 6 && bad < 200) begin
      @(posedge clk); #1;
      bad++;
    end
    chk("timeout_continue", 64'(nbytes >= 6), 64'd1);
    chk("timeout_error_sticky", 64'(error), 64'd1);
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
